// File: rtl/edid_image_loader.sv
// Loads the I2C EDID slave RAM from one of NUM_IMAGES source ROM images,
// sequencing hot-plug detect around the copy and repairing the checksum byte.
module edid_image_loader #(
    parameter int NUM_IMAGES     = 4,
    parameter int SEL_W          = 2,
    parameter int HPD_LOW_CYCLES = 10000000,
    parameter int FIX_CHECKSUM   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SEL_W-1:0]   sel,
    input  logic               load_req,
    input  logic               i2c_busy,
    output logic [SEL_W+6:0]   rom_addr,
    input  logic [7:0]         rom_data,
    output logic               edid_we,
    output logic [6:0]         edid_addr,
    output logic [7:0]         edid_wdata,
    output logic               hpd,
    output logic               busy,
    output logic               done,
    output logic               cksum_err
);

    localparam int CNT_W = (HPD_LOW_CYCLES > 1) ? $clog2(HPD_LOW_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HPD_LOW_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_MASK = SEL_W'(NUM_IMAGES - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HPD_LOW  = 3'd1;
    localparam logic [2:0] S_WAIT_I2C = 3'd2;
    localparam logic [2:0] S_COPY     = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0] r_sel_s1;
    logic [SEL_W-1:0] r_sel_s2;
    logic [SEL_W-1:0] r_sel_s3;
    logic [SEL_W-1:0] r_cur_sel;
    logic             r_pending;
    logic             r_rd_vld;
    logic             r_vld_p1;
    logic [6:0]       r_idx_p1;
    logic [7:0]       r_sum;
    logic [SEL_W+6:0] r_rom_addr;
    logic             r_hpd;
    logic             r_done;
    logic             r_cksum_err;

    logic             w_trig;
    logic             w_last_wr;
    logic [7:0]       w_wdata;

    function automatic logic [7:0] f_fix_cksum(input logic [7:0] sum);
        return 8'h00 - sum;
    endfunction

    // The whole image sums to zero exactly when the last byte is the repair value.
    function automatic logic f_cksum_bad(input logic [7:0] sum, input logic [7:0] last);
        logic [7:0] t;
        t = sum + last;
        return (t != 8'h00);
    endfunction

    assign w_trig    = load_req | (r_sel_s3 != r_cur_sel);
    assign w_last_wr = r_vld_p1 && (r_idx_p1 == 7'd127);

    always_comb begin
        w_wdata = 8'h00;
        if (r_vld_p1) begin
            if (w_last_wr && (FIX_CHECKSUM != 0))
                w_wdata = f_fix_cksum(r_sum);
            else
                w_wdata = rom_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_s1 <= '0;
            r_sel_s2 <= '0;
            r_sel_s3 <= '0;
        end else begin
            r_sel_s1 <= sel & SEL_MASK;
            r_sel_s2 <= r_sel_s1;
            r_sel_s3 <= r_sel_s2;
        end
    end

    // Write stage _p1: ROM data arrives one cycle after its address.
    always_ff @(posedge clk) begin
        if (r_vld_p1)
            r_sum <= ((r_idx_p1 == 7'd0) ? 8'h00 : r_sum) + rom_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_HPD_LOW;
            r_cnt       <= CNT_LOAD;
            r_cur_sel   <= '0;
            r_pending   <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_vld_p1    <= 1'b0;
            r_idx_p1    <= 7'd0;
            r_rom_addr  <= '0;
            r_hpd       <= 1'b0;
            r_done      <= 1'b0;
            r_cksum_err <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_vld_p1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        r_state     <= S_HPD_LOW;
                        r_hpd       <= 1'b0;
                        r_cnt       <= CNT_LOAD;
                        r_cur_sel   <= r_sel_s3;
                        r_cksum_err <= 1'b0;
                    end
                end
                S_HPD_LOW: begin
                    // Nothing copied yet, so simply follow the latest select.
                    r_cur_sel <= r_sel_s3;
                    if (load_req) begin
                        r_cnt <= CNT_LOAD;
                    end else if (r_cnt == '0) begin
                        if (i2c_busy) begin
                            r_state <= S_WAIT_I2C;
                        end else begin
                            r_state    <= S_COPY;
                            r_rom_addr <= {r_sel_s3, 7'd0};
                            r_rd_vld   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_WAIT_I2C: begin
                    r_cur_sel <= r_sel_s3;
                    if (load_req) begin
                        r_state <= S_HPD_LOW;
                        r_cnt   <= CNT_LOAD;
                    end else if (!i2c_busy) begin
                        r_state    <= S_COPY;
                        r_rom_addr <= {r_sel_s3, 7'd0};
                        r_rd_vld   <= 1'b1;
                    end
                end
                S_COPY: begin
                    if (w_trig)
                        r_pending <= 1'b1;
                    r_vld_p1 <= r_rd_vld;
                    r_idx_p1 <= r_rom_addr[6:0];
                    if (r_rd_vld) begin
                        if (r_rom_addr[6:0] == 7'd127)
                            r_rd_vld <= 1'b0;
                        else
                            r_rom_addr[6:0] <= r_rom_addr[6:0] + 7'd1;
                    end
                    if (w_last_wr) begin
                        r_cksum_err <= f_cksum_bad(r_sum, rom_data);
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // A request that arrived mid-copy reloads straight away with HPD kept low.
                    if (r_pending || w_trig) begin
                        r_pending   <= 1'b0;
                        r_state     <= S_HPD_LOW;
                        r_hpd       <= 1'b0;
                        r_cnt       <= CNT_LOAD;
                        r_cur_sel   <= r_sel_s3;
                        r_cksum_err <= 1'b0;
                    end else begin
                        r_hpd   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rom_addr   = r_rom_addr;
    assign edid_we    = r_vld_p1;
    assign edid_addr  = r_idx_p1;
    assign edid_wdata = w_wdata;
    assign hpd        = r_hpd;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign cksum_err  = r_cksum_err;

endmodule

// File: tb/tb_edid_image_loader.sv
// Randomized bench for edid_image_loader: random ROM images, a shadow EDID RAM
// and a plain-arithmetic model of the image that must land in it.
module tb_edid_image_loader;

    localparam int HPD   = 16;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [SEL_W-1:0] sel;
    logic             load_req;
    logic             i2c_busy;
    logic [SEL_W+6:0] rom_addr;
    logic [7:0]       rom_data;
    logic             edid_we;
    logic [6:0]       edid_addr;
    logic [7:0]       edid_wdata;
    logic             hpd;
    logic             busy;
    logic             done;
    logic             cksum_err;

    always #5 clk = ~clk;

    edid_image_loader #(
        .NUM_IMAGES    (4),
        .SEL_W         (SEL_W),
        .HPD_LOW_CYCLES(HPD),
        .FIX_CHECKSUM  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .load_req  (load_req),
        .i2c_busy  (i2c_busy),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .edid_we   (edid_we),
        .edid_addr (edid_addr),
        .edid_wdata(edid_wdata),
        .hpd       (hpd),
        .busy      (busy),
        .done      (done),
        .cksum_err (cksum_err)
    );

    logic [7:0] rom [0:511];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Shadow of the EDID RAM plus write-order bookkeeping.
    logic [7:0] shadow [0:127];
    int         wr_cnt     = 0;
    int         ord_err    = 0;
    int         we_hpd_err = 0;
    logic [6:0] prev_addr  = 7'd127;

    always @(negedge clk) begin
        if (edid_we) begin
            shadow[edid_addr] <= edid_wdata;
            wr_cnt            <= wr_cnt + 1;
            if (edid_addr != 7'(prev_addr + 7'd1) && edid_addr != 7'd0)
                ord_err <= ord_err + 1;
            prev_addr <= edid_addr;
            if (hpd)
                we_hpd_err <= we_hpd_err + 1;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sum_bytes(input int s, input int n);
        int acc;
        acc = 0;
        for (int i = 0; i < n; i++) acc += rom[s*128 + i];
        return 8'(acc % 256);
    endfunction

    function automatic logic [7:0] exp_byte(input int s, input int i);
        if (i < 127) return rom[s*128 + i];
        return 8'((256 - int'(sum_bytes(s, 127))) % 256);
    endfunction

    function automatic logic exp_err(input int s);
        return sum_bytes(s, 128) != 8'h00;
    endfunction

    function automatic int img_bad(input int s);
        int bad;
        bad = 0;
        for (int i = 0; i < 128; i++)
            if (shadow[i] !== exp_byte(s, i)) bad++;
        return bad;
    endfunction

    task automatic wait_we(input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (edid_we) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (done) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic finish_load(input string tag, input int s, input int base_wr);
        int n;
        wait_done(2000, n);
        chk_val({tag, "_done_seen"}, (n > 0), 1);
        chk_val({tag, "_wr_count"}, wr_cnt - base_wr, 128);
        chk_val({tag, "_image"}, img_bad(s), 0);
        chk_val({tag, "_cksum_err"}, cksum_err, exp_err(s));
        @(negedge clk);
        chk_val({tag, "_hpd_after"}, hpd, 1);
        chk_val({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, base, ord0, cur, s, acc;
        rst_n = 1'b0; sel = 2'd2; load_req = 1'b0; i2c_busy = 1'b0;

        // Images 0 and 2 valid; image 1 has a corrupt checksum; image 3 ends in
        // 0x00 while its true checksum is 0x5A.
        for (int img = 0; img < 4; img++) begin
            for (int i = 0; i < 127; i++) rom[img*128 + i] = 8'($urandom);
            rom[img*128 + 127] = 8'((256 - int'(sum_bytes(img, 127))) % 256);
        end
        rom[128 + 127] = rom[128 + 127] + 8'd1;
        acc = int'(sum_bytes(3, 126));
        rom[3*128 + 126] = 8'((256 + 'hA6 - acc) % 256);
        rom[3*128 + 127] = 8'h00;

        repeat (3) @(negedge clk);
        chk_val("rst_hpd", hpd, 0);
        chk_val("rst_we", edid_we, 0);
        chk_val("rst_done", done, 0);
        chk_val("rst_busy", busy, 1);
        chk_val("rst_cksum_err", cksum_err, 0);
        chk_val("rst_rom_addr", rom_addr, 0);
        chk_val("rst_edid_addr", edid_addr, 0);
        chk_val("rst_edid_wdata", edid_wdata, 0);

        // Automatic load after reset release.
        base = wr_cnt; ord0 = ord_err;
        rst_n = 1'b1;
        wait_we(100, n);
        chk_val("reset_load_latency", n, HPD + 1);
        chk_val("reset_load_first_addr", edid_addr, 0);
        chk_val("reset_load_hpd_low", hpd, 0);
        finish_load("reset_load", 2, base);
        cur = 2;

        // Bad checksum in image 3 is repaired and flagged, and stays flagged.
        base = wr_cnt;
        sel = 2'd3;
        finish_load("img3", 3, base);
        chk_val("img3_byte127", shadow[127], 8'h5A);
        repeat (5) @(negedge clk);
        chk_val("img3_err_sticky", cksum_err, 1);
        cur = 3;

        // sel 3->1 starts a load; change to 3 mid-copy must not abort image 1.
        base = wr_cnt;
        sel = 2'd1;
        repeat (6) @(negedge clk);
        chk_val("sel1_err_cleared", cksum_err, 0);
        wait_we(100, n);
        chk_val("sel1_started", (n > 0), 1);
        repeat ($urandom_range(10, 100)) @(negedge clk);
        sel = 2'd3;
        wait_done(2000, n);
        chk_val("pend_done_seen", (n > 0), 1);
        chk_val("pend_img1_wr_count", wr_cnt - base, 128);
        chk_val("pend_img1_image", img_bad(1), 0);
        chk_val("pend_img1_cksum_err", cksum_err, exp_err(1));
        chk_val("pend_done_hpd", hpd, 0);
        base = wr_cnt;
        @(negedge clk);
        chk_val("pend_hpd_held_low", hpd, 0);
        chk_val("pend_busy", busy, 1);
        wait_we(100, n);
        chk_val("pend_reload_latency", n, HPD + 1);
        finish_load("pend_img3", 3, base);
        cur = 3;

        // Back to a good image clears the error flag.
        base = wr_cnt;
        sel = 2'd2;
        finish_load("img2", 2, base);
        cur = 2;

        // I2C bus busy past the HPD-low period holds off the copy.
        i2c_busy = 1'b1;
        base = wr_cnt;
        pulse_load();
        repeat (HPD + 40) @(negedge clk);
        chk_val("i2c_no_write", wr_cnt - base, 0);
        chk_val("i2c_hpd_low", hpd, 0);
        i2c_busy = 1'b0;
        wait_we(20, n);
        chk_val("i2c_release_latency", n, 2);
        chk_val("i2c_first_addr", edid_addr, 0);
        finish_load("i2c", 2, base);

        // load_req at HPD-low count 5 restarts the low period.
        base = wr_cnt;
        pulse_load();
        repeat (10) @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk_val("restart_no_write", wr_cnt - base, 0);
        wait_we(100, n);
        chk_val("restart_latency", n, HPD + 1);
        chk_val("restart_hpd_low", hpd, 0);
        finish_load("restart", 2, base);

        // Random image selections.
        for (int it = 0; it < 4; it++) begin
            s = int'($urandom_range(0, 3));
            base = wr_cnt;
            if (s == cur) pulse_load();
            else sel = 2'(s);
            finish_load($sformatf("rand%0d_img%0d", it, s), s, base);
            cur = s;
        end

        // Reset in the middle of a copy, then a clean reload from byte 0.
        pulse_load();
        wait_we(100, n);
        chk_val("abort_started", (n > 0), 1);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (edid_we && edid_addr == 7'd60) begin
                n = 1;
                break;
            end
        end
        chk_val("abort_reached_byte60", n, 1);
        rst_n = 1'b0;
        #1;
        chk_val("abort_we", edid_we, 0);
        chk_val("abort_hpd", hpd, 0);
        chk_val("abort_busy", busy, 1);
        chk_val("abort_edid_addr", edid_addr, 0);
        @(negedge clk);
        @(negedge clk);
        base = wr_cnt;
        rst_n = 1'b1;
        wait_we(100, n);
        chk_val("abort_reload_latency", n, HPD + 1);
        chk_val("abort_reload_first_addr", edid_addr, 0);
        finish_load("abort_reload", cur, base);

        chk_val("write_order", ord_err - ord0, 0);
        chk_val("write_while_hpd", we_hpd_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
